inst_pipe_regs: RTL and testbench

- Produces the four pipeline instruction words (IF/ID, ID/EX, EX/MEM, MEM/WB) that the control decoder consumes.
- Advances fetched instructions through the five-stage pipeline.
- Detects RAW hazards and inserts bubbles. There is no forwarding.
- Flushes wrong-path instructions on a taken BEQ that resolves in MEM.
- Keeps saturating stall and flush performance counters.

---
 rtl/inst_pipe_regs_pkg.sv | 66 ++++++
 rtl/inst_pipe_regs_hazard_detect.sv | 37 +++
 rtl/inst_pipe_regs.sv | 99 +++++++++
 tb/tb_inst_pipe_regs.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pipe_regs_pkg.sv
// Shared MIPS32 instruction-set definitions: opcodes, function codes,
// the bubble word, field extraction and writer/reader classification.
package inst_pipe_regs_pkg;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_ALU  = 6'b000000,
        OP_BEQ  = 6'b000100,
        OP_ADDI = 6'b001000,
        OP_ANDI = 6'b001100,
        OP_ORI  = 6'b001101,
        OP_LW   = 6'b100011,
        OP_SW   = 6'b101011
    } opcode_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    function automatic logic [5:0] f_opcode(input logic [31:0] inst);
        return inst[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] inst);
        return inst[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] inst);
        return inst[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] inst);
        return inst[15:11];
    endfunction

    function automatic logic writes_rd(input logic [5:0] op);
        return op == OP_ALU;
    endfunction

    function automatic logic writes_rt(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LW);
    endfunction

    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

    // Destination register of an instruction; 0 when it writes nothing.
    function automatic logic [4:0] dest_of(input logic [31:0] inst);
        logic [5:0] op;
        op = f_opcode(inst);
        if (writes_rd(op)) begin
            return f_rd(inst);
        end
        if (writes_rt(op)) begin
            return f_rt(inst);
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/inst_pipe_regs_hazard_detect.sv
// RAW hazard detection between the ID instruction and the two older
// in-flight writers (EX and MEM). MEM/WB is not considered because the
// register file writes before it reads.
module hazard_detect
    import inst_pipe_regs_pkg::*;
(
    input  logic [31:0] ifid_inst,
    input  logic [31:0] idex_inst,
    input  logic [31:0] exmem_inst,
    output logic        stall
);

    logic [4:0] src_rs;
    logic [4:0] src_rt;
    logic [4:0] dest_ex;
    logic [4:0] dest_mem;
    logic       unused_bits;

    // Low fields never take part in source/destination extraction.
    assign unused_bits = ^{ifid_inst[15:0], idex_inst[10:0], exmem_inst[10:0]};

    // Compare each nonzero source of the ID instruction with both older destinations.
    always_comb begin
        src_rs   = f_rs(ifid_inst);
        src_rt   = reads_rt(f_opcode(ifid_inst)) ? f_rt(ifid_inst) : 5'd0;
        dest_ex  = dest_of(idex_inst);
        dest_mem = dest_of(exmem_inst);
        stall    = 1'b0;
        if ((src_rs != 5'd0) && ((src_rs == dest_ex) || (src_rs == dest_mem))) begin
            stall = 1'b1;
        end
        if ((src_rt != 5'd0) && ((src_rt == dest_ex) || (src_rt == dest_mem))) begin
            stall = 1'b1;
        end
    end

endmodule

// File: rtl/inst_pipe_regs.sv
// Five-stage pipeline instruction registers with RAW stall insertion,
// taken-BEQ flush and saturating stall/flush performance counters.
module inst_pipe_regs
    import inst_pipe_regs_pkg::*;
#(
    parameter logic [31:0] NOP_INST = inst_pipe_regs_pkg::NOP_INST,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      IF_Inst,
    input  logic             Branch_Taken,
    output logic [31:0]      PR_IFID_Inst,
    output logic [31:0]      PR_IDEX_Inst,
    output logic [31:0]      PR_EXMEM_Inst,
    output logic [31:0]      PR_MEMWB_Inst,
    output logic             PC_Hold,
    output logic             PC_Redirect,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    logic [31:0]      ifid_q,  ifid_d;
    logic [31:0]      idex_q,  idex_d;
    logic [31:0]      exmem_q, exmem_d;
    logic [31:0]      memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall;
    logic             flush;

    hazard_detect u_hazard (
        .ifid_inst  (ifid_q),
        .idex_inst  (idex_q),
        .exmem_inst (exmem_q),
        .stall      (stall)
    );

    // Branch_Taken only matters when a BEQ sits in EX/MEM.
    always_comb begin
        flush = Branch_Taken && (f_opcode(exmem_q) == OP_BEQ);
    end

    // Pipeline advance: flush outranks stall, stall outranks normal flow.
    always_comb begin
        ifid_d      = IF_Inst;
        idex_d      = ifid_q;
        exmem_d     = idex_q;
        memwb_d     = exmem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            ifid_d  = NOP_INST;
            idex_d  = NOP_INST;
            exmem_d = NOP_INST;
            if (!(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end else if (stall) begin
            ifid_d = ifid_q;
            idex_d = NOP_INST;
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset to the bubble state.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifid_q      <= NOP_INST;
            idex_q      <= NOP_INST;
            exmem_q     <= NOP_INST;
            memwb_q     <= NOP_INST;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ifid_q      <= ifid_d;
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // PC control and register outputs.
    always_comb begin
        PC_Hold       = stall && !flush;
        PC_Redirect   = flush;
        PR_IFID_Inst  = ifid_q;
        PR_IDEX_Inst  = idex_q;
        PR_EXMEM_Inst = exmem_q;
        PR_MEMWB_Inst = memwb_q;
        Stall_Count   = stall_cnt_q;
        Flush_Count   = flush_cnt_q;
    end

endmodule

// File: tb/tb_inst_pipe_regs.sv
// Bench for inst_pipe_regs: a stage-array model checked every cycle, plus
// directed scenarios with literal expectations. A second instance with
// 2-bit counters exercises counter saturation.
module tb_inst_pipe_regs;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IF_Inst;
    logic        Branch_Taken;

    logic [31:0] PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst, PR_MEMWB_Inst;
    logic        PC_Hold, PC_Redirect;
    logic [15:0] Stall_Count, Flush_Count;

    logic [31:0] s_ifid, s_idex, s_exmem, s_memwb;
    logic        s_hold, s_redirect;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clock = ~clock;

    inst_pipe_regs #(.NOP_INST(32'h0000_0000), .CNT_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .IF_Inst       (IF_Inst),
        .Branch_Taken  (Branch_Taken),
        .PR_IFID_Inst  (PR_IFID_Inst),
        .PR_IDEX_Inst  (PR_IDEX_Inst),
        .PR_EXMEM_Inst (PR_EXMEM_Inst),
        .PR_MEMWB_Inst (PR_MEMWB_Inst),
        .PC_Hold       (PC_Hold),
        .PC_Redirect   (PC_Redirect),
        .Stall_Count   (Stall_Count),
        .Flush_Count   (Flush_Count)
    );

    inst_pipe_regs #(.NOP_INST(32'h0000_0000), .CNT_W(2)) dut_sat (
        .clock         (clock),
        .reset         (reset),
        .IF_Inst       (IF_Inst),
        .Branch_Taken  (Branch_Taken),
        .PR_IFID_Inst  (s_ifid),
        .PR_IDEX_Inst  (s_idex),
        .PR_EXMEM_Inst (s_exmem),
        .PR_MEMWB_Inst (s_memwb),
        .PC_Hold       (s_hold),
        .PC_Redirect   (s_redirect),
        .Stall_Count   (s_stall_cnt),
        .Flush_Count   (s_flush_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st[0..3] = IF/ID, ID/EX, EX/MEM, MEM/WB
    logic [31:0] m_st [4];
    int          m_stalls = 0;
    int          m_flushes = 0;
    bit          m_valid = 1'b0;

    function automatic logic [4:0] spec_dest(input logic [31:0] w);
        case (w[31:26])
            6'b000000:                                  return w[15:11];
            6'b001000, 6'b001100, 6'b001101, 6'b100011: return w[20:16];
            default:                                    return 5'd0;
        endcase
    endfunction

    function automatic bit spec_stall();
        logic [4:0] srcs [2];
        bit hit = 1'b0;
        srcs[0] = m_st[0][25:21];
        srcs[1] = (m_st[0][31:26] inside {6'b000000, 6'b000100, 6'b101011}) ? m_st[0][20:16] : 5'd0;
        for (int p = 1; p <= 2; p++) begin
            for (int s = 0; s < 2; s++) begin
                if (srcs[s] != 5'd0 && srcs[s] == spec_dest(m_st[p])) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic bit spec_flush();
        return Branch_Taken && (m_st[2][31:26] == 6'b000100);
    endfunction

    function automatic logic [31:0] sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_st[i] <= 32'h0;
            m_stalls  <= 0;
            m_flushes <= 0;
            m_valid   <= 1'b1;
        end else if (m_valid) begin
            if (spec_flush()) begin
                m_st[0] <= 32'h0;
                m_st[1] <= 32'h0;
                m_st[2] <= 32'h0;
                m_st[3] <= m_st[2];
                m_flushes <= m_flushes + 1;
            end else if (spec_stall()) begin
                m_st[1] <= 32'h0;
                m_st[2] <= m_st[1];
                m_st[3] <= m_st[2];
                m_stalls <= m_stalls + 1;
            end else begin
                m_st[0] <= IF_Inst;
                m_st[1] <= m_st[0];
                m_st[2] <= m_st[1];
                m_st[3] <= m_st[2];
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("ifid", PR_IFID_Inst, m_st[0]);
            chk("idex", PR_IDEX_Inst, m_st[1]);
            chk("exmem", PR_EXMEM_Inst, m_st[2]);
            chk("memwb", PR_MEMWB_Inst, m_st[3]);
            chk("pc_hold", {31'b0, PC_Hold}, {31'b0, spec_stall() && !spec_flush()});
            chk("pc_redirect", {31'b0, PC_Redirect}, {31'b0, spec_flush()});
            chk("stall_cnt", {16'b0, Stall_Count}, sat(m_stalls, 65535));
            chk("flush_cnt", {16'b0, Flush_Count}, sat(m_flushes, 65535));
            chk("sat_ifid", s_ifid, m_st[0]);
            chk("sat_idex", s_idex, m_st[1]);
            chk("sat_exmem", s_exmem, m_st[2]);
            chk("sat_memwb", s_memwb, m_st[3]);
            chk("sat_hold", {31'b0, s_hold}, {31'b0, PC_Hold});
            chk("sat_redirect", {31'b0, s_redirect}, {31'b0, spec_flush()});
            chk("sat_stall_cnt", {30'b0, s_stall_cnt}, sat(m_stalls, 3));
            chk("sat_flush_cnt", {30'b0, s_flush_cnt}, sat(m_flushes, 3));
        end
    end

    // ---------------- directed stimulus ----------------
    localparam logic [31:0] ADD_A = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] ADD_B = 32'h00853020; // add $6,$4,$5
    localparam logic [31:0] ADD_C = 32'h00E84820; // add $9,$7,$8
    localparam logic [31:0] LW1   = 32'h8C410000; // lw $1,0($2)
    localparam logic [31:0] ADDI0 = 32'h20200005; // addi $0,$1,5
    localparam logic [31:0] ADD_0 = 32'h00021820; // add $3,$0,$2
    localparam logic [31:0] BEQ   = 32'h10220003; // beq $1,$2,3

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        IF_Inst      = 32'h0;
        Branch_Taken = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        IF_Inst      = ADD_A;
        Branch_Taken = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_ifid", PR_IFID_Inst, 32'h0);
        chk("rst_idex", PR_IDEX_Inst, 32'h0);
        chk("rst_exmem", PR_EXMEM_Inst, 32'h0);
        chk("rst_memwb", PR_MEMWB_Inst, 32'h0);
        chk("rst_stall_cnt", {16'b0, Stall_Count}, 32'd0);
        chk("rst_flush_cnt", {16'b0, Flush_Count}, 32'd0);
        chk("rst_pc_hold", {31'b0, PC_Hold}, 32'd0);

        // Independent stream: 4-cycle latency to MEM/WB
        do_reset();
        IF_Inst = ADD_A; tick();
        IF_Inst = ADD_B; tick();
        IF_Inst = ADD_C; tick();
        IF_Inst = 32'h0; tick();
        chk("ind_memwb_a", PR_MEMWB_Inst, ADD_A);
        tick();
        chk("ind_memwb_b", PR_MEMWB_Inst, ADD_B);
        tick();
        chk("ind_memwb_c", PR_MEMWB_Inst, ADD_C);
        chk("ind_stall_cnt", {16'b0, Stall_Count}, 32'd0);

        // Load-use: two bubbles
        do_reset();
        IF_Inst = LW1;   tick();
        IF_Inst = ADD_A; tick();
        IF_Inst = 32'h0; #1;
        chk("lu_hold1", {31'b0, PC_Hold}, 32'd1);
        tick();
        chk("lu_ifid_held", PR_IFID_Inst, ADD_A);
        chk("lu_idex_nop1", PR_IDEX_Inst, 32'h0);
        chk("lu_exmem_lw", PR_EXMEM_Inst, LW1);
        chk("lu_hold2", {31'b0, PC_Hold}, 32'd1);
        tick();
        chk("lu_idex_nop2", PR_IDEX_Inst, 32'h0);
        chk("lu_memwb_lw", PR_MEMWB_Inst, LW1);
        chk("lu_hold_off", {31'b0, PC_Hold}, 32'd0);
        tick();
        chk("lu_idex_add", PR_IDEX_Inst, ADD_A);
        chk("lu_stall_cnt", {16'b0, Stall_Count}, 32'd2);

        // $0 destination never stalls
        do_reset();
        IF_Inst = ADDI0; tick();
        IF_Inst = ADD_0; tick();
        IF_Inst = 32'h0; #1;
        chk("z_hold", {31'b0, PC_Hold}, 32'd0);
        tick();
        chk("z_idex", PR_IDEX_Inst, ADD_0);
        chk("z_stall_cnt", {16'b0, Stall_Count}, 32'd0);

        // Taken branch in EX/MEM
        do_reset();
        IF_Inst = BEQ;   tick();
        IF_Inst = ADD_B; tick();
        IF_Inst = ADD_C; tick();
        chk("br_exmem", PR_EXMEM_Inst, BEQ);
        IF_Inst = ADD_A; Branch_Taken = 1'b1; #1;
        chk("br_redirect", {31'b0, PC_Redirect}, 32'd1);
        tick();
        chk("br_ifid", PR_IFID_Inst, 32'h0);
        chk("br_idex", PR_IDEX_Inst, 32'h0);
        chk("br_exmem_nop", PR_EXMEM_Inst, 32'h0);
        chk("br_memwb", PR_MEMWB_Inst, BEQ);
        chk("br_flush_cnt", {16'b0, Flush_Count}, 32'd1);
        chk("br_redirect_off", {31'b0, PC_Redirect}, 32'd0);
        // Branch_Taken with a non-BEQ in EX/MEM has no effect
        IF_Inst = ADD_A; tick();
        IF_Inst = 32'h0; tick();
        tick();
        chk("nb_exmem", PR_EXMEM_Inst, ADD_A);
        chk("nb_redirect", {31'b0, PC_Redirect}, 32'd0);
        tick();
        chk("nb_memwb", PR_MEMWB_Inst, ADD_A);
        chk("nb_flush_cnt", {16'b0, Flush_Count}, 32'd1);
        Branch_Taken = 1'b0;

        // Flush beats a pending load-use stall
        do_reset();
        IF_Inst = BEQ;   tick();
        IF_Inst = LW1;   tick();
        IF_Inst = ADD_A; tick();
        Branch_Taken = 1'b1; IF_Inst = 32'h0; #1;
        chk("fs_hold", {31'b0, PC_Hold}, 32'd0);
        chk("fs_redirect", {31'b0, PC_Redirect}, 32'd1);
        tick();
        Branch_Taken = 1'b0;
        chk("fs_stall_cnt", {16'b0, Stall_Count}, 32'd0);
        chk("fs_flush_cnt", {16'b0, Flush_Count}, 32'd1);
        chk("fs_ifid", PR_IFID_Inst, 32'h0);

        // Reset asserted mid-stall
        do_reset();
        IF_Inst = LW1;   tick();
        IF_Inst = ADD_A; tick();
        IF_Inst = 32'h0; tick();
        chk("rs_stall_cnt1", {16'b0, Stall_Count}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rs_ifid", PR_IFID_Inst, 32'h0);
        chk("rs_exmem", PR_EXMEM_Inst, 32'h0);
        chk("rs_stall_cnt", {16'b0, Stall_Count}, 32'd0);

        // Saturation: 6 stalls then 4 flushes into 2-bit counters
        do_reset();
        repeat (3) begin
            IF_Inst = LW1;   tick();
            IF_Inst = ADD_A; tick();
            IF_Inst = 32'h0;
            repeat (4) tick();
        end
        chk("sat_stall_big", {16'b0, Stall_Count}, 32'd6);
        chk("sat_stall_small", {30'b0, s_stall_cnt}, 32'd3);
        IF_Inst = BEQ; Branch_Taken = 1'b1;
        repeat (16) tick();
        chk("sat_flush_big", {16'b0, Flush_Count}, 32'd4);
        chk("sat_flush_small", {30'b0, s_flush_cnt}, 32'd3);
        chk("sat_stall_small_held", {30'b0, s_stall_cnt}, 32'd3);
        Branch_Taken = 1'b0; IF_Inst = 32'h0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
